// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - two-player BCD score keeper with match FSM and frame-synced display
module score_keeper #(
    parameter int WIN_SCORE = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_point,
    input  logic       p2_point,
    input  logic       frame_tick,
    output logic [3:0] p1_tens,
    output logic [3:0] p1_ones,
    output logic [3:0] p2_tens,
    output logic [3:0] p2_ones,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       playing
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    state_t     state_q, state_d;
    logic       start_q;
    logic [7:0] p1_q, p1_d;
    logic [7:0] p2_q, p2_d;
    logic [1:0] winner_q, winner_d;
    logic       playing_q;
    logic [7:0] disp_p1_q, disp_p2_q;
    logic [1:0] disp_winner_q;
    logic       disp_over_q;
    logic       start_rise;
    logic       p1_win, p2_win;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    assign start_rise = start & ~start_q;

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        winner_d = winner_q;
        p1_win   = 1'b0;
        p2_win   = 1'b0;
        case (state_q)
            IDLE, GAME_OVER: begin
                if (start_rise) begin
                    p1_d     = 8'h00;
                    p2_d     = 8'h00;
                    winner_d = 2'b00;
                    state_d  = PLAY;
                end
            end
            PLAY: begin
                if (p1_point) p1_d = bcd_inc(p1_q);
                if (p2_point) p2_d = bcd_inc(p2_q);
                // Win is judged on the freshly incremented scores so both can land together.
                p1_win = p1_point && (p1_d == WIN_BCD);
                p2_win = p2_point && (p2_d == WIN_BCD);
                if (p1_win || p2_win) begin
                    winner_d = {p2_win, p1_win};
                    state_d  = GAME_OVER;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b1;
            p1_q          <= 8'h00;
            p2_q          <= 8'h00;
            winner_q      <= 2'b00;
            playing_q     <= 1'b0;
            disp_p1_q     <= 8'h00;
            disp_p2_q     <= 8'h00;
            disp_winner_q <= 2'b00;
            disp_over_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            winner_q  <= winner_d;
            playing_q <= (state_d == PLAY);
            // Snapshot the pre-edge values so a coincident point waits for the next frame.
            if (frame_tick) begin
                disp_p1_q     <= p1_q;
                disp_p2_q     <= p2_q;
                disp_winner_q <= winner_q;
                disp_over_q   <= (state_q == GAME_OVER);
            end
        end
    end

    assign p1_tens   = disp_p1_q[7:4];
    assign p1_ones   = disp_p1_q[3:0];
    assign p2_tens   = disp_p2_q[7:4];
    assign p2_ones   = disp_p2_q[3:0];
    assign game_over = disp_over_q;
    assign winner    = disp_winner_q;
    assign playing   = playing_q;
endmodule
